// File: rtl/tetris_board_pkg.sv
// ---------------------------------------------------------------------------
// tetris_board_pkg
// Shared constants and types for the Tetris board RAM and its arbiter.
//   BOARD_W / BOARD_H : playfield size in cells
//   BOARD_DEPTH       : number of board cells (default DEPTH of the arbiter)
//   BOARD_ADDR_W      : default address width
//   BOARD_DATA_W      : default cell colour width
//   owner_t           : ownership tag carried down the read-return pipeline
//   clr_state_t       : state encoding of the clear sequencer
// ---------------------------------------------------------------------------
package tetris_board_pkg;

    localparam int BOARD_W      = 10;
    localparam int BOARD_H      = 20;
    localparam int BOARD_DEPTH  = BOARD_W * BOARD_H;
    localparam int BOARD_ADDR_W = 8;
    localparam int BOARD_DATA_W = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_GM   = 2'd2,
        OWN_CLR  = 2'd3
    } owner_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/board_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter_if
// Bundles the three requester ports and the board RAM port of the arbiter.
//   vid_*  : render read port (pulse request, fixed-latency return)
//   gm_*   : game read/write port (level request, grant handshake)
//   clr_*  : clear command and busy status
//   oob_err: sticky out-of-range flag
//   mem_*  : registered single-port RAM port
// Handshake: vid_req is a one-cycle request that is always accepted in the
// cycle it is high. gm_req is a level "valid" held with stable
// gm_we/gm_addr/gm_wdata; gm_gnt is the combinational "ready" and the
// request is accepted in the cycle where gm_req && gm_gnt. Read data comes
// back exactly 3 cycles after acceptance as a one-cycle *_rvalid pulse.
// modport slave  : arbiter side
// modport master : requester / RAM side
// ---------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int ADDR_W = tetris_board_pkg::BOARD_ADDR_W,
    parameter int DATA_W = tetris_board_pkg::BOARD_DATA_W
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    logic              gm_req;
    logic              gm_we;
    logic [ADDR_W-1:0] gm_addr;
    logic [DATA_W-1:0] gm_wdata;
    logic              gm_gnt;
    logic              gm_rvalid;
    logic [DATA_W-1:0] gm_rdata;

    logic              clr_start;
    logic              clr_busy;
    logic              oob_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_rvalid, vid_rdata,
        input  gm_req, gm_we, gm_addr, gm_wdata,
        output gm_gnt, gm_rvalid, gm_rdata,
        input  clr_start,
        output clr_busy, oob_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_rvalid, vid_rdata,
        output gm_req, gm_we, gm_addr, gm_wdata,
        input  gm_gnt, gm_rvalid, gm_rdata,
        output clr_start,
        input  clr_busy, oob_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/board_clear_seq.sv
// ---------------------------------------------------------------------------
// board_clear_seq
// Two-state clear sequencer. On a start pulse in IDLE it walks clr_ptr over
// 0..DEPTH-1, offering one zero-write per cycle to the arbiter; the pointer
// only moves on cycles where the arbiter grants the write (i_advance).
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   i_clr_start   : clear command pulse (ignored while clearing)
//   i_advance     : the offered clear write was accepted this cycle
//   o_clr_req     : a clear write is being offered
//   o_clr_addr    : address of the offered clear write
//   o_clr_busy    : clear in progress
//   o_start_take  : start pulse being accepted this cycle (IDLE only)
//   o_state       : FSM state for debug
// ---------------------------------------------------------------------------
module board_clear_seq
    import tetris_board_pkg::*;
#(
    parameter int DEPTH  = BOARD_DEPTH,
    parameter int ADDR_W = BOARD_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_start,
    input  logic              i_advance,
    output logic              o_clr_req,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_busy,
    output logic              o_start_take,
    output clr_state_t        o_state
);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= CLR_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_clr_ptr;
        case (r_state)
            CLR_IDLE: begin
                if (i_clr_start) begin
                    w_state_nxt = CLR_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLR_CLEAR: begin
                if (i_advance) begin
                    // Leave as soon as the last write has been accepted.
                    if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = CLR_IDLE;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = CLR_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_clr_req    = (r_state == CLR_CLEAR);
    assign o_clr_addr   = r_clr_ptr;
    assign o_clr_busy   = (r_state == CLR_CLEAR);
    assign o_start_take = (r_state == CLR_IDLE) && i_clr_start;
    assign o_state      = r_state;

endmodule

// File: rtl/board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter
// Shares one single-port synchronous board RAM between the render path,
// the game logic and the clear sequencer. Fixed priority per cycle:
// render > clear > game. The RAM port is registered and read data returns
// through a two-stage tag pipeline plus an output register, giving a fixed
// 3-cycle read latency at one access per cycle.
// Ports:
//   clk, rst        : 100 MHz clock, synchronous active-low reset
//   bus             : requester + RAM signals (board_mem_arbiter_if.slave)
//   o_dbg_clr_state : clear sequencer FSM state for debug
// ---------------------------------------------------------------------------
module board_mem_arbiter
    import tetris_board_pkg::*;
#(
    parameter int DEPTH  = BOARD_DEPTH,
    parameter int ADDR_W = BOARD_ADDR_W,
    parameter int DATA_W = BOARD_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    board_mem_arbiter_if.slave   bus,
    output clr_state_t           o_dbg_clr_state
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // Clear sequencer handshake
    logic              w_clr_req;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_busy;
    logic              w_start_take;
    logic              w_clr_adv;

    // Arbitration result for this cycle
    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    owner_t            w_owner;
    logic              w_gm_gnt;
    logic              w_oob;

    // RAM port and return pipeline
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    owner_t            r_tag1;
    owner_t            r_tag2;
    logic              r_rd1;
    logic              r_rd2;
    logic              r_zero1;
    logic              r_zero2;
    logic              r_vid_rvalid;
    logic [DATA_W-1:0] r_vid_rdata;
    logic              r_gm_rvalid;
    logic [DATA_W-1:0] r_gm_rdata;
    logic              r_oob_err;

    board_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk          (clk),
        .rst          (rst),
        .i_clr_start  (bus.clr_start),
        .i_advance    (w_clr_adv),
        .o_clr_req    (w_clr_req),
        .o_clr_addr   (w_clr_addr),
        .o_clr_busy   (w_clr_busy),
        .o_start_take (w_start_take),
        .o_state      (o_dbg_clr_state)
    );

    always_comb begin
        w_acc     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_owner   = OWN_NONE;
        w_gm_gnt  = 1'b0;
        w_clr_adv = 1'b0;
        if (bus.vid_req) begin
            w_acc   = 1'b1;
            w_addr  = bus.vid_addr;
            w_owner = OWN_VID;
        end else if (w_clr_req) begin
            w_acc     = 1'b1;
            w_we      = 1'b1;
            w_addr    = w_clr_addr;
            w_owner   = OWN_CLR;
            w_clr_adv = 1'b1;
        end else if (bus.gm_req && !w_start_take) begin
            // A clear being started this cycle already blocks the game.
            w_acc    = 1'b1;
            w_we     = bus.gm_we;
            w_addr   = bus.gm_addr;
            w_wdata  = bus.gm_wdata;
            w_owner  = OWN_GM;
            w_gm_gnt = 1'b1;
        end
    end

    // Out-of-range slots are consumed but never reach the RAM.
    assign w_oob = w_acc && ({1'b0, w_addr} >= DEPTH_X);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_tag1       <= OWN_NONE;
            r_tag2       <= OWN_NONE;
            r_rd1        <= 1'b0;
            r_rd2        <= 1'b0;
            r_zero1      <= 1'b0;
            r_zero2      <= 1'b0;
            r_vid_rvalid <= 1'b0;
            r_vid_rdata  <= '0;
            r_gm_rvalid  <= 1'b0;
            r_gm_rdata   <= '0;
            r_oob_err    <= 1'b0;
        end else begin
            r_mem_en    <= w_acc && !w_oob;
            r_mem_we    <= w_acc && w_we && !w_oob;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;

            r_tag1  <= w_owner;
            r_rd1   <= w_acc && !w_we;
            r_zero1 <= w_oob;

            r_tag2  <= r_tag1;
            r_rd2   <= r_rd1;
            r_zero2 <= r_zero1;

            // Return steering by tag only; out-of-range reads return zero.
            r_vid_rvalid <= r_rd2 && (r_tag2 == OWN_VID);
            r_gm_rvalid  <= r_rd2 && (r_tag2 == OWN_GM);
            if (r_rd2 && (r_tag2 == OWN_VID)) begin
                r_vid_rdata <= r_zero2 ? '0 : bus.mem_rdata;
            end
            if (r_rd2 && (r_tag2 == OWN_GM)) begin
                r_gm_rdata <= r_zero2 ? '0 : bus.mem_rdata;
            end

            if (w_oob) begin
                r_oob_err <= 1'b1;
            end
        end
    end

    assign bus.gm_gnt     = w_gm_gnt & rst;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.vid_rvalid = r_vid_rvalid;
    assign bus.vid_rdata  = r_vid_rdata;
    assign bus.gm_rvalid  = r_gm_rvalid;
    assign bus.gm_rdata   = r_gm_rdata;
    assign bus.clr_busy   = w_clr_busy;
    assign bus.oob_err    = r_oob_err;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_mem_arbiter
// Directed bench for board_mem_arbiter with a behavioural board RAM.
// ---------------------------------------------------------------------------
module tb_board_mem_arbiter;
    import tetris_board_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    clr_state_t dbg_state;

    board_mem_arbiter #(
        .DEPTH  (200),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .o_dbg_clr_state (dbg_state)
    );

    // ---------------- board RAM model ----------------
    // fill_mode: 0 normal, 1 all sevens, 2 address pattern
    logic [DATA_W-1:0] ram [0:255];
    logic [1:0]        fill_mode;

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [7:0] a;
        a = i[7:0];
        return a[2:0] ^ 3'b110;
    endfunction

    always @(posedge clk) begin
        if (fill_mode != 2'd0) begin
            for (int j = 0; j < 256; j++) begin
                ram[j] <= (fill_mode == 2'd1) ? 3'd7 : pat(j);
            end
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    // ---------------- monitor ----------------
    int busy_cnt = 0;
    int we_cnt   = 0;
    int gnt_cnt  = 0;
    logic [DATA_W-1:0] vid_obs_q[$];

    always @(negedge clk) begin
        if (bus.clr_busy) busy_cnt <= busy_cnt + 1;
        if (bus.mem_we)   we_cnt   <= we_cnt + 1;
        if (bus.gm_gnt)   gnt_cnt  <= gnt_cnt + 1;
        if (bus.vid_rvalid) vid_obs_q.push_back(bus.vid_rdata);
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [1:0] mode);
        fill_mode = mode;
        step();
        fill_mode = 2'd0;
    endtask

    task automatic gm_read_check(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp, input string tag);
        bus.gm_req  = 1'b1;
        bus.gm_we   = 1'b0;
        bus.gm_addr = addr;
        #1;
        check_eq({tag, "_gnt"}, 32'(bus.gm_gnt), 32'd1);
        step();
        bus.gm_req = 1'b0;
        step();
        step();
        check_eq({tag, "_rvalid"}, 32'(bus.gm_rvalid), 32'd1);
        check_eq({tag, "_rdata"}, 32'(bus.gm_rdata), 32'(exp));
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vid_rvalid"}, 32'(bus.vid_rvalid), 32'd0);
        check_eq({tag, "_vid_rdata"},  32'(bus.vid_rdata),  32'd0);
        check_eq({tag, "_gm_gnt"},     32'(bus.gm_gnt),     32'd0);
        check_eq({tag, "_gm_rvalid"},  32'(bus.gm_rvalid),  32'd0);
        check_eq({tag, "_gm_rdata"},   32'(bus.gm_rdata),   32'd0);
        check_eq({tag, "_clr_busy"},   32'(bus.clr_busy),   32'd0);
        check_eq({tag, "_oob_err"},    32'(bus.oob_err),    32'd0);
        check_eq({tag, "_mem_en"},     32'(bus.mem_en),     32'd0);
        check_eq({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        check_eq({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        check_eq({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
        check_eq({tag, "_state"},      32'(dbg_state),      32'(CLR_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy0, we0, gnt0, vbase, nz;
        logic [ADDR_W-1:0] a;

        rst           = 1'b0;
        fill_mode     = 2'd0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.gm_req    = 1'b1;
        bus.gm_we     = 1'b0;
        bus.gm_addr   = 8'd4;
        bus.gm_wdata  = '0;
        bus.clr_start = 1'b0;

        // Reset state (gm_req held high: grant must still be 0)
        repeat (3) step();
        check_all_zero("reset");
        bus.gm_req = 1'b0;
        rst = 1'b1;
        do_fill(2'd2);

        // Single game read of addr 5 (RAM[5]=3)
        bus.gm_req  = 1'b1;
        bus.gm_we   = 1'b0;
        bus.gm_addr = 8'd5;
        #1;
        check_eq("rd5_gnt", 32'(bus.gm_gnt), 32'd1);
        step();
        bus.gm_req = 1'b0;
        check_eq("rd5_mem_en", 32'(bus.mem_en), 32'd1);
        check_eq("rd5_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rd5_mem_addr", 32'(bus.mem_addr), 32'd5);
        check_eq("rd5_rvalid_n1", 32'(bus.gm_rvalid), 32'd0);
        step();
        check_eq("rd5_rvalid_n2", 32'(bus.gm_rvalid), 32'd0);
        step();
        check_eq("rd5_rvalid_n3", 32'(bus.gm_rvalid), 32'd1);
        check_eq("rd5_rdata", 32'(bus.gm_rdata), 32'd3);
        step();
        check_eq("rd5_rvalid_n4", 32'(bus.gm_rvalid), 32'd0);

        // Conflict: render read 7 vs game write 9 <- 4
        bus.vid_req  = 1'b1;
        bus.vid_addr = 8'd7;
        bus.gm_req   = 1'b1;
        bus.gm_we    = 1'b1;
        bus.gm_addr  = 8'd9;
        bus.gm_wdata = 3'd4;
        #1;
        check_eq("cf_gnt_n0", 32'(bus.gm_gnt), 32'd0);
        step();
        bus.vid_req = 1'b0;
        #1;
        check_eq("cf_gnt_n1", 32'(bus.gm_gnt), 32'd1);
        check_eq("cf_mem_en_n1", 32'(bus.mem_en), 32'd1);
        check_eq("cf_mem_we_n1", 32'(bus.mem_we), 32'd0);
        check_eq("cf_mem_addr_n1", 32'(bus.mem_addr), 32'd7);
        step();
        bus.gm_req = 1'b0;
        bus.gm_we  = 1'b0;
        check_eq("cf_mem_we_n2", 32'(bus.mem_we), 32'd1);
        check_eq("cf_mem_addr_n2", 32'(bus.mem_addr), 32'd9);
        check_eq("cf_mem_wdata_n2", 32'(bus.mem_wdata), 32'd4);
        step();
        check_eq("cf_vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
        check_eq("cf_vid_rdata", 32'(bus.vid_rdata), 32'd1);
        check_eq("cf_gm_rvalid", 32'(bus.gm_rvalid), 32'd0);
        step();
        check_eq("cf_vid_rvalid_off", 32'(bus.vid_rvalid), 32'd0);
        check_eq("cf_gm_rvalid_wr", 32'(bus.gm_rvalid), 32'd0);
        check_eq("cf_ram9", 32'(ram[9]), 32'd4);

        // Out of range: game read at 200, then game write at 250
        check_eq("oob_before", 32'(bus.oob_err), 32'd0);
        bus.gm_req  = 1'b1;
        bus.gm_we   = 1'b0;
        bus.gm_addr = 8'd200;
        #1;
        check_eq("oob_rd_gnt", 32'(bus.gm_gnt), 32'd1);
        step();
        bus.gm_req = 1'b0;
        check_eq("oob_rd_mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("oob_err_set", 32'(bus.oob_err), 32'd1);
        step();
        step();
        check_eq("oob_rd_rvalid", 32'(bus.gm_rvalid), 32'd1);
        check_eq("oob_rd_rdata", 32'(bus.gm_rdata), 32'd0);
        bus.gm_req   = 1'b1;
        bus.gm_we    = 1'b1;
        bus.gm_addr  = 8'd250;
        bus.gm_wdata = 3'd5;
        #1;
        check_eq("oob_wr_gnt", 32'(bus.gm_gnt), 32'd1);
        step();
        bus.gm_req = 1'b0;
        bus.gm_we  = 1'b0;
        check_eq("oob_wr_mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("oob_wr_mem_we", 32'(bus.mem_we), 32'd0);
        repeat (5) step();
        check_eq("oob_wr_no_rvalid", 32'(bus.gm_rvalid), 32'd0);
        check_eq("oob_err_sticky", 32'(bus.oob_err), 32'd1);

        // Clear with render every 4th cycle, game request held
        do_fill(2'd1);
        busy0 = busy_cnt;
        we0   = we_cnt;
        gnt0  = gnt_cnt;
        vbase = vid_obs_q.size();
        exp_q.delete();
        bus.clr_start = 1'b1;
        bus.gm_req    = 1'b1;
        bus.gm_we     = 1'b0;
        bus.gm_addr   = 8'd3;
        #1;
        check_eq("clr_start_gnt", 32'(bus.gm_gnt), 32'd0);
        check_eq("clr_busy_n0", 32'(bus.clr_busy), 32'd0);
        step();
        bus.clr_start = 1'b0;
        check_eq("clr_busy_n1", 32'(bus.clr_busy), 32'd1);
        check_eq("clr_state", 32'(dbg_state), 32'(CLR_CLEAR));
        // 200 writes at 3 per 4 cycles: 66 full groups + vid,w,w = 267 cycles
        for (int k = 0; k < 267; k++) begin
            bus.clr_start = (k == 100);
            bus.vid_req   = ((k % 4) == 0);
            if ((k % 4) == 0) begin
                a = 8'((k * 13) % 200);
                bus.vid_addr = a;
                // zero writes already accepted before cycle k: k - ceil(k/4)
                exp_q.push_back((int'(a) < (k - (k + 3) / 4)) ? 3'd0 : 3'd7);
            end
            step();
        end
        bus.vid_req   = 1'b0;
        bus.gm_req    = 1'b0;
        bus.clr_start = 1'b0;
        check_eq("clr_busy_done", 32'(bus.clr_busy), 32'd0);
        repeat (4) step();
        check_eq("clr_busy_cycles", 32'(busy_cnt - busy0), 32'd267);
        check_eq("clr_write_cnt", 32'(we_cnt - we0), 32'd200);
        check_eq("clr_gnt_cnt", 32'(gnt_cnt - gnt0), 32'd0);
        check_eq("clr_vid_cnt", 32'(vid_obs_q.size() - vbase), 32'd67);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (vbase + i < vid_obs_q.size()) begin
                check_eq($sformatf("clr_vid_%0d", i), 32'(vid_obs_q[vbase + i]), 32'(exp_q[i]));
            end
        end
        nz = 0;
        for (int j = 0; j < 200; j++) begin
            if (ram[j] != 3'd0) nz++;
        end
        check_eq("clr_ram_nonzero", 32'(nz), 32'd0);

        // Reset after 50 clear writes
        do_fill(2'd2);
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        repeat (50) step();
        rst = 1'b0;
        step();
        check_all_zero("midclr");
        rst = 1'b1;
        step();
        gm_read_check(8'd49, 3'd0, "midclr_rd49");
        gm_read_check(8'd50, 3'd4, "midclr_rd50");

        // Reset while a read is in flight
        bus.gm_req  = 1'b1;
        bus.gm_we   = 1'b0;
        bus.gm_addr = 8'd5;
        step();
        bus.gm_req = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("midrd_rvalid_%0d", i), 32'(bus.gm_rvalid), 32'd0);
            step();
        end

        // Back-to-back render for 640 cycles, game request held
        do_fill(2'd2);
        gnt0  = gnt_cnt;
        vbase = vid_obs_q.size();
        exp_q.delete();
        bus.gm_req  = 1'b1;
        bus.gm_we   = 1'b0;
        bus.gm_addr = 8'd2;
        for (int k = 0; k < 640; k++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 8'(k % 200);
            exp_q.push_back(pat(k % 200));
            step();
        end
        bus.vid_req = 1'b0;
        #1;
        check_eq("b2b_gnt_cnt", 32'(gnt_cnt - gnt0), 32'd0);
        check_eq("b2b_gnt_after", 32'(bus.gm_gnt), 32'd1);
        step();
        bus.gm_req = 1'b0;
        repeat (4) step();
        check_eq("b2b_vid_cnt", 32'(vid_obs_q.size() - vbase), 32'd640);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (vbase + i < vid_obs_q.size()) begin
                check_eq($sformatf("b2b_vid_%0d", i), 32'(vid_obs_q[vbase + i]), 32'(exp_q[i]));
            end
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
